// File: rtl/ex_mem_flag_stage_pkg.sv
// rtl/ex_mem_flag_stage_pkg.sv - shared opcodes, branch conditions, widths and flag reset values
package ex_mem_flag_stage_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_RED = 3'b011;

    localparam logic [2:0] BR_NEQ    = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_GT     = 3'b010;
    localparam logic [2:0] BR_LT     = 3'b011;
    localparam logic [2:0] BR_GTE    = 3'b100;
    localparam logic [2:0] BR_LTE    = 3'b101;
    localparam logic [2:0] BR_OVFL   = 3'b110;
    localparam logic [2:0] BR_UNCOND = 3'b111;

    localparam logic FLAG_Z_RST = 1'b1;
    localparam logic FLAG_V_RST = 1'b0;
    localparam logic FLAG_N_RST = 1'b0;

    // Only the arithmetic ops produce meaningful V/N; everything else updates Z alone.
    function automatic logic op_loads_all_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/ex_mem_flag_stage_br_cond_eval.sv
// rtl/ex_mem_flag_stage_br_cond_eval.sv - branch condition evaluator, shared with the decode predictor
module br_cond_eval
    import ex_mem_flag_stage_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            BR_NEQ:    take = ~z;
            BR_EQ:     take = z;
            BR_GT:     take = ~z & ~n;
            BR_LT:     take = n;
            BR_GTE:    take = z | (~z & ~n);
            BR_LTE:    take = n | z;
            BR_OVFL:   take = v;
            BR_UNCOND: take = 1'b1;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// rtl/ex_mem_flag_stage.sv - EX/MEM register with Z/V/N flags and branch resolve; BR_STATS_EN adds branch counters
module ex_mem_flag_stage
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [2:0]    ex_op,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          ex_z,
    input  logic          ex_v,
    input  logic          ex_n,
    input  logic          ex_set_flags,
    input  logic          ex_is_br,
    input  logic [2:0]    ex_br_cond,
    input  logic [DW-1:0] ex_br_target,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_we,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic [DW-1:0] ex_store_data,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_out,
    output logic [RW-1:0] mem_rd,
    output logic          mem_we,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic [DW-1:0] mem_store_data,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          br_taken,
    output logic [DW-1:0] br_target
`ifdef BR_STATS_EN
    ,
    output logic [15:0]   br_total,
    output logic [15:0]   br_taken_cnt
`endif
);

    logic cond_take;
    logic advance;

    // Branches see only committed flags, so a flag-setter one slot ahead is already visible.
    br_cond_eval u_br_cond_eval (
        .cond (ex_br_cond),
        .z    (flag_z),
        .v    (flag_v),
        .n    (flag_n),
        .take (cond_take)
    );

    assign advance   = ~stall & ~flush;
    assign br_taken  = ex_valid & ex_is_br & cond_take & ~flush;
    assign br_target = ex_br_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_we         <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
            flag_z         <= FLAG_Z_RST;
            flag_v         <= FLAG_V_RST;
            flag_n         <= FLAG_N_RST;
        end else if (flush) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_mem_rd <= 1'b0;
            mem_mem_wr <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_out    <= ex_alu_out;
            mem_rd         <= ex_rd;
            mem_we         <= ex_valid & ex_we;
            mem_mem_rd     <= ex_valid & ex_mem_rd;
            mem_mem_wr     <= ex_valid & ex_mem_wr;
            mem_store_data <= ex_store_data;
            if (ex_valid && ex_set_flags) begin
                flag_z <= ex_z;
                if (op_loads_all_flags(ex_op)) begin
                    flag_v <= ex_v;
                    flag_n <= ex_n;
                end
            end
        end
    end

`ifdef BR_STATS_EN
    logic br_adv;
    assign br_adv = ex_valid & ex_is_br & advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total     <= 16'd0;
            br_taken_cnt <= 16'd0;
        end else if (br_adv) begin
            if (br_total != 16'hFFFF)
                br_total <= br_total + 16'd1;
            if (br_taken && (br_taken_cnt != 16'hFFFF))
                br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb/tb_ex_mem_flag_stage.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_ex_mem_flag_stage;
    import ex_mem_flag_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, ex_valid;
    logic [2:0]  ex_op;
    logic [15:0] ex_alu_out;
    logic        ex_z, ex_v, ex_n, ex_set_flags, ex_is_br;
    logic [2:0]  ex_br_cond;
    logic [15:0] ex_br_target;
    logic [3:0]  ex_rd;
    logic        ex_we, ex_mem_rd, ex_mem_wr;
    logic [15:0] ex_store_data;
    logic        mem_valid;
    logic [15:0] mem_alu_out;
    logic [3:0]  mem_rd;
    logic        mem_we, mem_mem_rd, mem_mem_wr;
    logic [15:0] mem_store_data;
    logic        flag_z, flag_v, flag_n;
    logic        br_taken;
    logic [15:0] br_target;
`ifdef BR_STATS_EN
    logic [15:0] br_total, br_taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_flag_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_op(ex_op), .ex_alu_out(ex_alu_out), .ex_z(ex_z), .ex_v(ex_v), .ex_n(ex_n),
        .ex_set_flags(ex_set_flags), .ex_is_br(ex_is_br), .ex_br_cond(ex_br_cond),
        .ex_br_target(ex_br_target), .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .mem_valid(mem_valid),
        .mem_alu_out(mem_alu_out), .mem_rd(mem_rd), .mem_we(mem_we), .mem_mem_rd(mem_mem_rd),
        .mem_mem_wr(mem_mem_wr), .mem_store_data(mem_store_data), .flag_z(flag_z),
        .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken), .br_target(br_target)
`ifdef BR_STATS_EN
        , .br_total(br_total), .br_taken_cnt(br_taken_cnt)
`endif
    );

    typedef struct packed {
        logic        stall, flush, valid;
        logic [2:0]  op;
        logic        z, v, n, sf, is_br;
        logic [2:0]  cond;
        logic [15:0] tgt, alu;
        logic [3:0]  rd;
        logic        we;
        logic        e_br, e_valid, e_we;
        logic [2:0]  e_flags;
        logic        chk;
        logic [15:0] e_alu;
        logic [3:0]  e_rd;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(input int st, fl, va, op, z, v, n, sf, br, cond, tgt, alu, rd, we,
                                input int eb, ev, ewe, ef, chk, ealu, erd);
        vec_t t;
        t.stall = 1'(st); t.flush = 1'(fl); t.valid = 1'(va); t.op = 3'(op);
        t.z = 1'(z); t.v = 1'(v); t.n = 1'(n); t.sf = 1'(sf); t.is_br = 1'(br);
        t.cond = 3'(cond); t.tgt = 16'(tgt); t.alu = 16'(alu); t.rd = 4'(rd); t.we = 1'(we);
        t.e_br = 1'(eb); t.e_valid = 1'(ev); t.e_we = 1'(ewe); t.e_flags = 3'(ef);
        t.chk = 1'(chk); t.e_alu = 16'(ealu); t.e_rd = 4'(erd);
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        stall = t.stall; flush = t.flush; ex_valid = t.valid; ex_op = t.op;
        ex_z = t.z; ex_v = t.v; ex_n = t.n; ex_set_flags = t.sf; ex_is_br = t.is_br;
        ex_br_cond = t.cond; ex_br_target = t.tgt; ex_alu_out = t.alu; ex_rd = t.rd;
        ex_we = t.we; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_store_data = t.alu ^ 16'hFFFF;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    endtask

    // Branch rule from the condition table, phrased in terms of what each condition means.
    function automatic logic cond_ok(input logic [2:0] c, input logic z, v, n);
        case (c)
            BR_NEQ:  return !z;
            BR_EQ:   return z;
            BR_GT:   return !(z || n);
            BR_LT:   return n;
            BR_GTE:  return z || !n;
            BR_LTE:  return z || n;
            BR_OVFL: return v;
            default: return 1'b1;
        endcase
    endfunction

    // reference model state
    logic        m_valid, m_we, m_mrd, m_mwr, m_known;
    logic [15:0] m_alu, m_sd;
    logic [3:0]  m_rd;
    logic        mz, mv, mn;
    int          m_tot, m_tk;

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0; m_known = 1;
        m_alu = 0; m_sd = 0; m_rd = 0; mz = 1; mv = 0; mn = 0; m_tot = 0; m_tk = 0;
    endtask

    initial begin
        tv[0]  = mk(0,0,1,0,       0,0,0, 0,1,BR_EQ,    'h10,'h0,   0,0, 1,1,0,'b100,1,'h0,   0);
        tv[1]  = mk(0,0,1,OP_ADD,  0,1,1, 1,0,0,        0,   'h5,   1,1, 0,1,1,'b011,1,'h5,   1);
        tv[2]  = mk(0,0,1,OP_XOR,  1,0,0, 1,0,0,        0,   'h7,   2,1, 0,1,1,'b111,1,'h7,   2);
        tv[3]  = mk(0,0,1,OP_SUB,  1,0,0, 1,0,0,        0,   'h0,   3,1, 0,1,1,'b100,1,'h0,   3);
        tv[4]  = mk(0,0,1,0,       0,0,0, 0,1,BR_NEQ,   'h40,'h0,   0,0, 0,1,0,'b100,1,'h0,   0);
        tv[5]  = mk(0,0,1,0,       0,0,0, 0,1,BR_EQ,    'h40,'h0,   0,0, 1,1,0,'b100,1,'h0,   0);
        tv[6]  = mk(0,0,1,OP_ADD,  0,0,0, 0,0,0,        0,   'h1234,5,1, 0,1,1,'b100,1,'h1234,5);
        tv[7]  = mk(1,0,1,OP_ADD,  0,1,1, 1,0,0,        0,   'hBEEF,9,0, 0,1,1,'b100,1,'h1234,5);
        tv[8]  = mk(1,0,1,OP_SUB,  0,1,1, 1,0,0,        0,   'hBEF0,10,0,0,1,1,'b100,1,'h1234,5);
        tv[9]  = mk(1,0,0,OP_XOR,  0,1,1, 1,0,0,        0,   'hBEF1,11,0,0,1,1,'b100,1,'h1234,5);
        tv[10] = mk(1,1,1,OP_ADD,  0,1,0, 1,1,BR_UNCOND,'h80,'h9,   6,1, 0,0,0,'b100,0,'h0,   0);
        tv[11] = mk(0,0,1,0,       0,0,0, 0,1,BR_GT,    'h44,'h0,   0,0, 0,1,0,'b100,1,'h0,   0);
        tv[12] = mk(0,0,1,OP_RED,  0,1,1, 1,0,0,        0,   'h22,  7,1, 0,1,1,'b000,1,'h22,  7);
        tv[13] = mk(0,0,1,0,       0,0,0, 0,1,BR_GT,    'h48,'h0,   0,0, 1,1,0,'b000,1,'h0,   0);
        tv[14] = mk(0,0,1,0,       0,0,0, 0,1,BR_OVFL,  'h4C,'h0,   0,0, 0,1,0,'b000,1,'h0,   0);
        tv[15] = mk(0,0,1,0,       0,0,0, 0,1,BR_LT,    'h50,'h0,   0,0, 0,1,0,'b000,1,'h0,   0);
        tv[16] = mk(0,0,1,0,       0,0,0, 0,1,BR_GTE,   'h54,'h0,   0,0, 1,1,0,'b000,1,'h0,   0);
        tv[17] = mk(0,0,0,0,       0,0,0, 0,1,BR_UNCOND,'h58,'h33,  8,1, 0,0,0,'b000,1,'h33,  8);
        tv[18] = mk(0,0,0,OP_ADD,  1,1,1, 1,0,0,        0,   'h44,  8,1, 0,0,0,'b000,1,'h44,  8);

        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {mem_valid, mem_we, mem_mem_rd, mem_mem_wr}, 4'b0000);
        check("rst_data", {mem_alu_out, mem_rd, mem_store_data}, 36'h0);
        check("rst_flags", {flag_z, flag_v, flag_n}, 3'b100);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tv[i]);
            #1;
            check($sformatf("br_taken[%0d]", i), br_taken, tv[i].e_br);
            check($sformatf("br_target[%0d]", i), br_target, tv[i].tgt);
            @(posedge clk);
            #1;
            check($sformatf("ctrl[%0d]", i), {mem_valid, mem_we}, {tv[i].e_valid, tv[i].e_we});
            check($sformatf("flags[%0d]", i), {flag_z, flag_v, flag_n}, tv[i].e_flags);
            if (tv[i].chk)
                check($sformatf("data[%0d]", i), {mem_alu_out, mem_rd}, {tv[i].e_alu, tv[i].e_rd});
        end

        // async reset with an instruction in MEM and a taken branch pending in EX
        drive(mk(0,0,1,OP_ADD, 0,1,1, 1,0,0, 0,'h77,3,1, 0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(0,0,1,0, 0,0,0, 0,1,BR_UNCOND, 'h60,'h0,0,0, 0,0,0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {mem_valid, mem_we}, 2'b00);
        check("async_rst_flags", {flag_z, flag_v, flag_n}, 3'b100);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

`ifdef BR_STATS_EN
        for (int i = 0; i < 7; i++) begin
            // 3 taken, 2 not taken, 1 stalled, 1 flushed
            drive(mk(i == 5, i == 6, 1, 0, 0,0,0, 0,1, (i == 3 || i == 4) ? BR_OVFL : BR_UNCOND,
                     'h100 + i, 0, 0, 0, 0,0,0,0,0,0,0));
            @(posedge clk);
            #1;
        end
        check("br_total", br_total, 16'd5);
        check("br_taken_cnt", br_taken_cnt, 16'd3);
        idle();
        @(posedge clk);
        #1;
        m_tot = 5; m_tk = 3;
        m_valid = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            logic exp_br;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 7) == 0;
            ex_valid = ($urandom % 4) != 0;
            ex_op = 3'($urandom); ex_z = 1'($urandom); ex_v = 1'($urandom); ex_n = 1'($urandom);
            ex_set_flags = 1'($urandom); ex_is_br = 1'($urandom); ex_br_cond = 3'($urandom);
            ex_br_target = 16'($urandom); ex_alu_out = 16'($urandom); ex_rd = 4'($urandom);
            ex_we = 1'($urandom); ex_mem_rd = 1'($urandom); ex_mem_wr = 1'($urandom);
            ex_store_data = 16'($urandom);
            #1;
            exp_br = ex_valid && ex_is_br && !flush && cond_ok(ex_br_cond, mz, mv, mn);
            check("rnd_br_taken", br_taken, exp_br);
            if (flush) begin
                m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0; m_known = 0;
            end else if (!stall) begin
                if (ex_is_br && ex_valid) begin
                    if (m_tot < 65535) m_tot++;
                    if (exp_br && m_tk < 65535) m_tk++;
                end
                m_valid = ex_valid;
                m_we = ex_valid && ex_we; m_mrd = ex_valid && ex_mem_rd; m_mwr = ex_valid && ex_mem_wr;
                m_alu = ex_alu_out; m_rd = ex_rd; m_sd = ex_store_data; m_known = 1;
                if (ex_valid && ex_set_flags) begin
                    mz = ex_z;
                    if (ex_op == OP_ADD || ex_op == OP_SUB) begin
                        mv = ex_v; mn = ex_n;
                    end
                end
            end
            @(posedge clk);
            #1;
            check("rnd_ctrl", {mem_valid, mem_we, mem_mem_rd, mem_mem_wr}, {m_valid, m_we, m_mrd, m_mwr});
            check("rnd_flags", {flag_z, flag_v, flag_n}, {mz, mv, mn});
            if (m_known)
                check("rnd_data", {mem_alu_out, mem_rd, mem_store_data}, {m_alu, m_rd, m_sd});
`ifdef BR_STATS_EN
            check("rnd_stats", {br_total, br_taken_cnt}, {16'(m_tot), 16'(m_tk)});
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- EX/MEM pipeline boundary that sits directly downstream of the 16-bit ALU.
- Latches the ALU result and the control fields that travel with it into the MEM stage.
- Owns the architectural Z/V/N flag register and updates it per ALU opcode.
- Resolves conditional branches in EX against the committed flags, producing a taken/target pair that redirects fetch.

Parameters:
- DW, 16, datapath width (ALU result, store data, PC values).
- RW, 4, register-specifier width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state.
- flush  in  1  convert the current EX instruction into a bubble.
- ex_valid  in  1  EX holds a real instruction.
- ex_op  in  3  ALU opcode (000 ADD, 001 SUB, 010 XOR, 011 RED, 1xx shift/rotate/PADDSB).
- ex_alu_out  in  DW  ALU result.
- ex_z, ex_v, ex_n  in  1 each  ALU flag outputs.
- ex_set_flags  in  1  instruction is an ALU operation that may write flags.
- ex_is_br  in  1  conditional/unconditional branch.
- ex_br_cond  in  3  branch condition code.
- ex_br_target  in  DW  computed branch target.
- ex_rd  in  RW  destination register.
- ex_we  in  1  register write enable.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_store_data  in  DW  store data.
- mem_valid  out  1  MEM holds a real instruction.
- mem_alu_out  out  DW  latched ALU result / address.
- mem_rd  out  RW  latched destination register.
- mem_we, mem_mem_rd, mem_mem_wr  out  1 each  latched controls.
- mem_store_data  out  DW  latched store data.
- flag_z, flag_v, flag_n  out  1 each  architectural flags.
- br_taken  out  1  combinational; redirect fetch this cycle.
- br_target  out  DW  combinational; equals ex_br_target.

Behaviour:
- Reset (async, rst_n=0):
  - All mem_* outputs = 0, including mem_valid.
  - flag_z = 1; flag_v = 0; flag_n = 0.
  - Recovery is synchronous to clk.
- Latency: one cycle EX->MEM. Flags become visible one cycle after the producing instruction's EX cycle.
- Priority per edge is flush > stall > normal.
  - flush=1: mem_valid <= 0 and mem_we/mem_mem_rd/mem_mem_wr <= 0. Data fields may load; they are don't-care. Flags unchanged.
  - stall=1 (no flush): every register, including the flags, holds.
  - Normal: all mem_* load from the ex_* inputs. mem_valid <= ex_valid. When ex_valid=0, the controls load as 0.
- Flag update occurs only when ex_valid & ex_set_flags & ~stall & ~flush:
  - op 000 or 001: Z, V and N all load.
  - All other ops: only Z loads; V and N hold.
  - Branch, load, store and bubble instructions never touch the flags.
- Branch resolution (combinational), evaluated on the registered flags, never on ex_z/ex_v/ex_n:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 always
- br_taken = ex_valid & ex_is_br & cond & ~flush. stall does not gate br_taken; the fetch unit ignores redirects while stalled.
- Hazard-free by construction: an older flag-setting instruction has already written the flags at its EX->MEM edge by the time a following branch sits in EX.
- Reset asserted mid-operation: immediate clear. A pending branch is lost and mem_valid=0.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined: adds two output ports, br_total [15:0] and br_taken_cnt [15:0].
  - Both are 16-bit saturating counters (hold at 16'hFFFF) and are reset to 0 by rst_n.
  - br_total increments once per branch that advances, i.e. ex_valid & ex_is_br & ~stall & ~flush.
  - br_taken_cnt increments on the same condition AND br_taken.
- Undefined: the ports and counters are absent. Remaining behaviour is identical.

Decomposition:
- Shared package contains:
  - ALU opcode constants (OP_ADD=3'b000, OP_SUB=3'b001, OP_XOR=3'b010, OP_RED=3'b011).
  - Branch condition constants (BR_NEQ..BR_UNCOND).
  - DW/RW defaults.
  - Flag reset values.
- One combinational sub-module, br_cond_eval: inputs cond[2:0], z, v, n; output take. This module is reused by the decode-stage predictor.

Test Plan:
- Reset, then a branch with cond EQ, ex_valid=1 -> br_taken=1, because Z resets to 1; all mem_* outputs are 0.
- ADD with ex_z=0, ex_v=1, ex_n=1, then one edge -> flags Z=0, V=1, N=1. Next, XOR with ex_z=1, ex_v=0, ex_n=0 -> Z=1, V=1, N=1.
- SUB result 0x0000 with ex_z=1, immediately followed by branch NEQ with target 0x0040 -> br_taken=0. Then branch EQ -> br_taken=1, br_target=0x0040.
- Load an ALU result of 0x1234 with rd=5, we=1, then stall=1 for 3 cycles with differing inputs -> mem_alu_out stays 0x1234, mem_rd stays 5, and the flags stay unchanged throughout.
- flush=1 and stall=1 together with ADD ex_v=1 -> mem_valid=0, mem_we=0, V unchanged, br_taken=0.
- With BR_STATS_EN defined: 3 taken branches, 2 not-taken, 1 stalled, 1 flushed -> br_total=5, br_taken_cnt=3.
